// File: rtl/group_arr_plane_sequencer.sv
// Piled-to-planar reorder: buffers ARR_L elements, then emits PLANE_N planar words (plane 0 first).
// Zero-bubble into EMIT on the last accept; in_ready is low while emitting, out_ready low stalls EMIT.
module group_arr_plane_sequencer #(
  parameter int ARR_L   = 32,
  parameter int ELE_W   = 8,
  parameter int PLANE_N = 4,
  parameter int IDX_W   = (PLANE_N > 1) ? $clog2(PLANE_N) : 1,
  parameter int CNT_W   = $clog2(ARR_L + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PLANE_N*ELE_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ARR_L*ELE_W-1:0]   out_plane,
  output logic [IDX_W-1:0]         out_plane_idx,
  output logic                     out_last,
  output logic [CNT_W-1:0]         fill_cnt
);

  localparam int SLOT_W = (ARR_L > 1) ? $clog2(ARR_L) : 1;

  typedef enum logic {FILL, EMIT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Stored field-major per slot so the plane gather is a plain index per slot.
  logic [ELE_W-1:0] buf_q [ARR_L][PLANE_N];

  logic              in_acc;
  logic [SLOT_W-1:0] wr_slot;

  assign in_acc  = in_valid & in_ready & ~clear;
  assign wr_slot = fill_cnt_q[SLOT_W-1:0];

  always_ff @(posedge clk) begin
    if (in_acc) begin
      for (int k = 0; k < PLANE_N; k++) begin
        buf_q[wr_slot][k] <= in_data[k*ELE_W +: ELE_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    idx_d      = idx_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fill_cnt_d = fill_cnt_q + CNT_W'(1);
          if (fill_cnt_q == CNT_W'(ARR_L - 1)) begin
            state_d = EMIT;
            idx_d   = '0;
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (out_last) begin
            state_d    = FILL;
            fill_cnt_d = '0;
            idx_d      = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d    = FILL;
        fill_cnt_d = '0;
        idx_d      = '0;
      end
    endcase
    // Abort wins over any handshake presented in the same cycle.
    if (clear) begin
      state_d    = FILL;
      fill_cnt_d = '0;
      idx_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    out_plane = '0;
    for (int i = 0; i < ARR_L; i++) begin
      out_plane[i*ELE_W +: ELE_W] = buf_q[i][idx_q];
    end
  end

  assign out_plane_idx = idx_q;
  assign out_last      = (idx_q == IDX_W'(PLANE_N - 1));
  assign fill_cnt      = fill_cnt_q;

endmodule

// File: tb/tb_group_arr_plane_sequencer.sv
// Bench for group_arr_plane_sequencer with ARR_L=4, ELE_W=8, PLANE_N=4.
// Expected planes are queued as groups are driven and popped on each output accept.
module tb_group_arr_plane_sequencer;

  localparam int ARR_L   = 4;
  localparam int ELE_W   = 8;
  localparam int PLANE_N = 4;

  typedef struct packed {
    logic        last;
    logic [1:0]  idx;
    logic [31:0] plane;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_plane;
  logic [1:0]  out_plane_idx;
  logic        out_last;
  logic [2:0]  fill_cnt;

  int   checks;
  int   errors;
  int   cyc;
  exp_t sb_q[$];

  group_arr_plane_sequencer #(
    .ARR_L(ARR_L), .ELE_W(ELE_W), .PLANE_N(PLANE_N), .IDX_W(2), .CNT_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_plane(out_plane),
    .out_plane_idx(out_plane_idx), .out_last(out_last), .fill_cnt(fill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] field(input int base, input int k, input int i);
    return 8'(((base + k) << 4) | i);
  endfunction

  function automatic logic [31:0] elem(input int base, input int i);
    return {field(base, 3, i), field(base, 2, i), field(base, 1, i), field(base, 0, i)};
  endfunction

  task automatic push_planes(input int base, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.last  = (k == PLANE_N - 1);
      e.idx   = 2'(k);
      e.plane = {field(base, k, 3), field(base, k, 2), field(base, k, 1), field(base, k, 0)};
      sb_q.push_back(e);
    end
  endtask

  // One clock cycle: scoreboard sampled at the falling edge, then advance to just past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready && !clear) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plane: got idx=%0d plane=%h with no plane expected", out_plane_idx, out_plane);
      end else begin
        e = sb_q.pop_front();
        if ({out_last, out_plane_idx, out_plane} !== e) begin
          errors++;
          $display("FAIL plane_data: got last=%b idx=%0d plane=%h, expected last=%b idx=%0d plane=%h",
                   out_last, out_plane_idx, out_plane, e.last, e.idx, e.plane);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_elem(input logic [31:0] d);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 50 && !done; t++) begin
      if (in_ready && !clear) done = 1;
      cycle();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b, expected 1 within 50 cycles", in_ready);
    end
  endtask

  task automatic send_group(input int base, input int n);
    for (int i = 0; i < n; i++) send_elem(elem(base, i));
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      cycle();
      t++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d planes outstanding, expected 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, fill_cnt, out_plane_idx, out_last} !== {1'b0, 1'b1, 3'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got vld=%b rdy=%b cnt=%0d idx=%0d last=%b, expected 0 1 0 0 0",
               out_valid, in_ready, fill_cnt, out_plane_idx, out_last);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    push_planes(0, PLANE_N);
    send_group(0, 3);
    checks++;
    if (out_valid !== 1'b0 || fill_cnt !== 3'd3) begin
      errors++;
      $display("FAIL basic_partial: got vld=%b cnt=%0d, expected 0 3", out_valid, fill_cnt);
    end
    send_elem(elem(0, 3));
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || fill_cnt !== 3'd4) begin
      errors++;
      $display("FAIL basic_emit_start: got vld=%b rdy=%b cnt=%0d, expected 1 0 4", out_valid, in_ready, fill_cnt);
    end
    cyc = 0;
    drain("basic");
    checks++;
    if (cyc != PLANE_N) begin
      errors++;
      $display("FAIL basic_emit_cycles: got %0d cycles, expected %0d", cyc, PLANE_N);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || fill_cnt !== 3'd0) begin
      errors++;
      $display("FAIL basic_return: got rdy=%b vld=%b cnt=%0d, expected 1 0 0", in_ready, out_valid, fill_cnt);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    push_planes(0, PLANE_N);
    send_group(0, ARR_L);
    cycle();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    for (int t = 0; t < 5; t++) begin
      cycle();
      checks++;
      if (out_plane !== 32'h13121110 || out_plane_idx !== 2'd1 || in_ready !== 1'b0 ||
          out_valid !== 1'b1 || fill_cnt !== 3'd4) begin
        errors++;
        $display("FAIL stall_hold: got plane=%h idx=%0d rdy=%b vld=%b cnt=%0d, expected 13121110 1 0 1 4",
                 out_plane, out_plane_idx, in_ready, out_valid, fill_cnt);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("stall");
  endtask

  task automatic test_gapped();
    out_ready = 1'b1;
    push_planes(0, PLANE_N);
    for (int i = 0; i < ARR_L; i++) begin
      send_elem(elem(0, i));
      if (i < ARR_L - 1) begin
        for (int g = 0; g < 2; g++) begin
          in_data = 32'hFFFFFFFF;
          cycle();
          checks++;
          if (fill_cnt !== 3'(i + 1)) begin
            errors++;
            $display("FAIL gapped_cnt: got %0d, expected %0d", fill_cnt, i + 1);
          end
        end
      end
    end
    drain("gapped");
  endtask

  task automatic test_clear_fill();
    out_ready = 1'b1;
    send_group(0, 2);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    checks++;
    if (fill_cnt !== 3'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_fill_cnt: got cnt=%0d rdy=%b, expected 0 1", fill_cnt, in_ready);
    end
    push_planes(4, PLANE_N);
    send_group(4, ARR_L);
    drain("clear_fill");
  endtask

  task automatic test_clear_emit();
    out_ready = 1'b1;
    push_planes(0, 2);
    send_group(0, ARR_L);
    cycle();
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_plane_idx !== 2'd2 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL clear_emit_pre: got vld=%b idx=%0d pending=%0d, expected 1 2 0",
               out_valid, out_plane_idx, sb_q.size());
    end
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || fill_cnt !== 3'd0 || out_plane_idx !== 2'd0) begin
      errors++;
      $display("FAIL clear_emit_post: got vld=%b rdy=%b cnt=%0d idx=%0d, expected 0 1 0 0",
               out_valid, in_ready, fill_cnt, out_plane_idx);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    send_group(0, 3);
    checks++;
    if (fill_cnt !== 3'd3) begin
      errors++;
      $display("FAIL areset_pre: got cnt=%0d, expected 3", fill_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fill_cnt !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_plane_idx !== 2'd0) begin
      errors++;
      $display("FAIL areset_now: got cnt=%0d rdy=%b vld=%b idx=%0d, expected 0 1 0 0",
               fill_cnt, in_ready, out_valid, out_plane_idx);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_planes(4, PLANE_N);
    send_group(4, ARR_L);
    drain("areset");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    push_planes(0, PLANE_N);
    push_planes(4, PLANE_N);
    cyc = 0;
    send_group(0, ARR_L);
    send_group(4, ARR_L);
    drain("b2b");
    checks++;
    if (cyc != 2 * (ARR_L + PLANE_N)) begin
      errors++;
      $display("FAIL b2b_period: got %0d cycles, expected %0d", cyc, 2 * (ARR_L + PLANE_N));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_basic();
    test_stall();
    test_gapped();
    test_clear_fill();
    test_clear_emit();
    test_async_reset();
    test_back_to_back();
    repeat (3) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/group_arr_plane_sequencer.md
Name: group_arr_plane_sequencer

Overview:
- Streaming controller for the piled-to-planar array reorder path in the SIFT feature pipeline.
- Accepts one piled element per handshake; each element holds PLANE_N fields of ELE_W bits.
- Buffers ARR_L elements, then emits the array as PLANE_N planar words, one plane per output handshake, in plane order 0..PLANE_N-1.
- Sits between per-pixel producers (pyramid and DoG stages) and plane-wide consumers that need all field-k values of a group on one bus.

Parameters:
- ARR_L, 32, number of elements per group.
- ELE_W, 8, width of each field in bits.
- PLANE_N, 4, fields per element and planes per group, 2..4.
- IDX_W, max(1, clog2(PLANE_N)), width of the plane index.
- CNT_W, clog2(ARR_L+1), width of the fill count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort of the current group.
- in_valid  in  1  input element valid.
- in_ready  out  1  block can accept an element.
- in_data  in  PLANE_N*ELE_W  piled element; field k is at bits [k*ELE_W +: ELE_W].
- out_valid  out  1  planar word valid.
- out_ready  in  1  consumer accepts the planar word.
- out_plane  out  ARR_L*ELE_W  planar word; element i of plane k is at bits [i*ELE_W +: ELE_W].
- out_plane_idx  out  IDX_W  index k of the plane currently on out_plane.
- out_last  out  1  high when out_plane_idx == PLANE_N-1.
- fill_cnt  out  CNT_W  elements stored in the current group.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = FILL, fill_cnt = 0, out_plane_idx = 0.
  - out_valid = 0, out_last = 0, in_ready = 1.
  - Buffer contents are don't-care.
- The buffer holds ARR_L slots of PLANE_N*ELE_W bits. A slot is written only on an input accept.
- State FILL:
  - in_ready = 1, out_valid = 0.
  - An accept occurs on in_valid & in_ready. It writes in_data to slot fill_cnt, then increments fill_cnt.
  - An accept at fill_cnt == ARR_L-1 moves the block to EMIT on the same edge, with fill_cnt = ARR_L and out_plane_idx = 0.
- State EMIT:
  - in_ready = 0, out_valid = 1.
  - out_plane is the combinational gather of field out_plane_idx from slots 0..ARR_L-1, with slot 0 at the LSBs. It stays stable while out_valid is high and not accepted.
  - An output accept occurs on out_valid & out_ready.
  - If out_last is high, the accept returns the block to FILL with fill_cnt = 0 and out_plane_idx = 0.
  - Otherwise the accept increments out_plane_idx.
- Latency:
  - out_valid rises on the edge that accepts the last element (zero bubble).
  - The first input accept of the next group can occur on the cycle after the last-plane accept.
  - Minimum period per group is ARR_L + PLANE_N cycles.
- Backpressure:
  - out_ready low holds EMIT indefinitely with outputs unchanged.
  - in_valid low in FILL holds fill_cnt.
- clear (synchronous, highest priority):
  - Forces FILL, fill_cnt = 0, out_plane_idx = 0 and out_valid = 0 on the next edge.
  - An element or plane presented in the same cycle as clear is not accepted; the producer must not treat it as consumed. in_ready and out_valid are unaffected by clear in that cycle; they change only after the edge.
  - Buffer contents are not cleared.
- Reset mid-group or mid-emit: all partial data is discarded and the block returns to the reset values above.
- in_data is ignored when no accept occurs. out_plane is don't-care while out_valid = 0.

Test Plan:
All scenarios use ARR_L=4, ELE_W=8, PLANE_N=4. Element i is sent as {8'h3i, 8'h2i, 8'h1i, 8'h0i}.

1. Reset, then 4 back-to-back elements with out_ready=1:
   - out_valid rises the cycle after the 4th accept.
   - Planes appear on 4 consecutive cycles: 32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130, with idx 0..3 and out_last only on idx 3.
   - in_ready returns to 1 in the following cycle.
2. Same stimulus with out_ready=0 for 5 cycles at idx 1:
   - out_plane holds 32'h13121110 and idx holds 1.
   - in_ready stays 0 throughout.
   - Emission resumes correctly once out_ready returns to 1.
3. Gapped input (in_valid toggling 1,0,0,1,...):
   - fill_cnt increments only on accepts.
   - Output is identical to scenario 1.
4. clear asserted after 2 accepts, then 4 new elements with base value 8'h4i:
   - fill_cnt reads 0 after the clear edge.
   - Plane 0 = 32'h43424140; no stale data appears in the output.
5. clear asserted in EMIT at idx 2 while out_ready=1:
   - Plane 2 is not accepted.
   - out_valid = 0 and state is FILL on the next cycle.
6. rst_n pulsed low mid-FILL (fill_cnt=3), asynchronous to clk:
   - Outputs drop to reset values immediately.
   - A subsequent full group emits correct planes.
